// File: rtl/paddle_pkg.sv
// Shared types and widths for the paddle digitiser: FSM encoding, position/scanline widths,
// and the 9-bit to 8-bit scanline clamp.
package paddle_pkg;

  localparam int POS_W  = 8;
  localparam int LINE_W = 9;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_HELD   = 2'd1,
    ST_COMMIT = 2'd2
  } paddle_state_t;

  // Scanlines past the 8-bit range saturate rather than wrap.
  function automatic logic [POS_W-1:0] clamp_line(input logic [LINE_W-1:0] line);
    logic [POS_W-1:0] res;
    if (line > 9'd255) res = 8'hFF;
    else               res = line[POS_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous input plus a third flop for rising-edge detection.
// Shared by any asynchronous button or paddle line.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/paddle_reader.sv
// Paddle digitiser: timestamps the first valid paddle edge per frame with the scanline and
// commits it on the vsync rising edge. Optional output smoothing under `PADDLE_SMOOTH_EN`.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARMED  | waiting for the frame's first edge at or past MIN_LINE
// ST_HELD   | edge captured, later edges ignored until vsync
// ST_COMMIT | one cycle: outputs load on the following clock
module paddle_reader
  import paddle_pkg::*;
#(
  parameter logic [LINE_W-1:0] MIN_LINE    = 9'd8,
  parameter logic [POS_W-1:0]  TIMEOUT_POS = 8'd255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic [LINE_W-1:0] vpos,
  input  logic              paddle_in,
  output logic [POS_W-1:0]  paddle_pos,
  output logic              pos_valid,
  output logic              timeout
);

  paddle_state_t state;
  paddle_state_t state_nxt;

  logic             rise;
  logic             vsync_q;
  logic             vsync_rise;
  logic             got_edge;
  logic             capture_en;
  logic [POS_W-1:0] cap;
  logic [POS_W-1:0] raw;
  logic [POS_W-1:0] new_pos;

  sync_rise_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (paddle_in),
    .rise     (rise)
  );

  assign vsync_rise = vsync & ~vsync_q;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_ARMED;
    else       state <= state_nxt;
  end

  // vsync_rise takes priority so an edge landing on the frame boundary belongs to neither frame.
  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    case (state)
      ST_ARMED: begin
        if (vsync_rise) begin
          state_nxt = ST_COMMIT;
        end else if (rise && (vpos >= MIN_LINE)) begin
          capture_en = 1'b1;
          state_nxt  = ST_HELD;
        end
      end
      ST_HELD: begin
        if (vsync_rise) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_nxt = ST_ARMED;
      end
      default: begin
        state_nxt = ST_ARMED;
      end
    endcase
  end

  assign raw = got_edge ? cap : TIMEOUT_POS;

`ifdef PADDLE_SMOOTH_EN
  logic [POS_W:0] smooth_sum;

  always_comb begin
    smooth_sum = {1'b0, raw} + {1'b0, paddle_pos} + {{POS_W{1'b0}}, 1'b1};
    new_pos    = smooth_sum[POS_W:1];
  end
`else
  assign new_pos = raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      got_edge   <= 1'b0;
      cap        <= '0;
      paddle_pos <= '0;
      pos_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      pos_valid <= (state == ST_COMMIT);
      if (capture_en) begin
        cap      <= clamp_line(vpos);
        got_edge <= 1'b1;
      end
      if (state == ST_COMMIT) begin
        paddle_pos <= new_pos;
        timeout    <= ~got_edge;
        got_edge   <= 1'b0;
      end
    end
  end

endmodule
